mod12_event_monitor: RTL and testbench

Downstream checker and event extractor for the mod-12 up/down counter. Each cycle it samples the counter's output and the controls that drove it, and recomputes the expected next count. It classifies every transition as a step, load, wrap or error. Wraps are accumulated into a cascaded epoch count, and notable transitions are queued in a small valid/ready event FIFO for a consumer.

---
 rtl/mod12_event_monitor.sv | 163 ++++++++++++++++
 tb/tb_mod12_event_monitor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mod12_event_monitor.sv
// mod12_event_monitor
//   Checks a mod-12 up/down counter against the controls that drove it and
//   classifies every transition as STEP, LOAD, WRAP_UP, WRAP_DN, ERR or RANGE.
//   Wraps feed a net epoch counter. Every non-STEP transition is queued in a
//   first-word-fall-through event FIFO with a valid/ready head.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   en                        monitor enable (0 suspends checking, drops history)
//   cnt_in, load_in,
//   datain_in, mode_in        counter output and the controls applied this cycle
//   wrap_cnt, wrap_ovf        net epoch count and its sticky rollover flag
//   err, err_cnt              sticky error flag and saturating error count
//   evt_valid, evt_ready,
//   evt_data                  FIFO head handshake; data = {type, dir, cnt}
//   evt_drop                  sticky; an event was lost to a full FIFO
module mod12_event_monitor #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WRAP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        cnt_in,
  input  logic              load_in,
  input  logic [3:0]        datain_in,
  input  logic              mode_in,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              wrap_ovf,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [7:0]        evt_data,
  output logic              evt_drop
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    EVT_STEP    = 3'b000,
    EVT_LOAD    = 3'b001,
    EVT_WRAP_UP = 3'b010,
    EVT_WRAP_DN = 3'b011,
    EVT_RANGE   = 3'b110,
    EVT_ERR     = 3'b111
  } evt_type_t;

  // History of the previous enabled cycle
  logic [3:0] prev_cnt;
  logic       prev_load;
  logic [3:0] prev_datain;
  logic       prev_mode;
  logic       prev_vld;

  // Event FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;

  logic       load_taken;
  logic [3:0] exp_cnt;
  evt_type_t  evt_type;
  logic       push;
  logic       pop;
  logic       push_ok;
  logic [7:0] evt_word;

  always_comb begin
    load_taken = prev_load && (prev_datain < 4'd12);
    if (load_taken)
      exp_cnt = prev_datain;
    else if (prev_mode)
      exp_cnt = (prev_cnt == 4'd11) ? 4'd0 : prev_cnt + 4'd1;
    else
      exp_cnt = (prev_cnt == 4'd0) ? 4'd11 : prev_cnt - 4'd1;

    evt_type = EVT_STEP;
    if (en && prev_vld) begin
      if (cnt_in > 4'd11)                      evt_type = EVT_RANGE;
      else if (cnt_in != exp_cnt)              evt_type = EVT_ERR;
      else if (load_taken)                     evt_type = EVT_LOAD;
      else if (prev_mode && prev_cnt == 4'd11) evt_type = EVT_WRAP_UP;
      else if (!prev_mode && prev_cnt == 4'd0) evt_type = EVT_WRAP_DN;
    end

    evt_word = {evt_type, prev_mode, cnt_in};
    push     = (evt_type != EVT_STEP);
    pop      = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push_ok  = push && ((fifo_cnt != FULL_CNT) || pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cnt    <= '0;
      prev_load   <= 1'b0;
      prev_datain <= '0;
      prev_mode   <= 1'b0;
      prev_vld    <= 1'b0;
    end else if (en) begin
      prev_cnt    <= cnt_in;
      prev_load   <= load_in;
      prev_datain <= datain_in;
      prev_mode   <= mode_in;
      prev_vld    <= 1'b1;
    end else begin
      prev_vld    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_cnt <= '0;
      wrap_ovf <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      case (evt_type)
        EVT_WRAP_UP: begin
          wrap_cnt <= wrap_cnt + WRAP_W'(1);
          if (wrap_cnt == '1) wrap_ovf <= 1'b1;
        end
        EVT_WRAP_DN: begin
          wrap_cnt <= wrap_cnt - WRAP_W'(1);
          if (wrap_cnt == '0) wrap_ovf <= 1'b1;
        end
        EVT_ERR, EVT_RANGE: begin
          err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      evt_drop <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= evt_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (push && !push_ok) evt_drop <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign evt_valid = (fifo_cnt != '0);
  assign evt_data  = mem[rd_ptr];

endmodule

// File: tb/tb_mod12_event_monitor.sv
module tb_mod12_event_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] cnt_in;
  logic       load_in;
  logic [3:0] datain_in;
  logic       mode_in;
  logic [7:0] wrap_cnt;
  logic       wrap_ovf;
  logic       err;
  logic [7:0] err_cnt;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_data;
  logic       evt_drop;

  int total = 0;
  int bad   = 0;

  mod12_event_monitor #(.FIFO_DEPTH(4), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .load_in(load_in),
    .datain_in(datain_in), .mode_in(mode_in), .wrap_cnt(wrap_cnt),
    .wrap_ovf(wrap_ovf), .err(err), .err_cnt(err_cnt), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_data(evt_data), .evt_drop(evt_drop)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic e, input logic [3:0] c, input logic m,
                     input logic l, input logic [3:0] d);
    en = e; cnt_in = c; mode_in = m; load_in = l; datain_in = d;
    @(posedge clk);
    #1;
  endtask

  // Drop history for one cycle, then capture a fresh starting point
  task automatic resync(input logic [3:0] c, input logic m,
                        input logic l, input logic [3:0] d);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, c, m, l, d);
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; cnt_in = '0; load_in = 1'b0; datain_in = '0;
    mode_in = 1'b0; evt_ready = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    total++; if (wrap_cnt !== 8'd0) begin bad++; $display("FAIL reset_wrap_cnt got=%h want=00", wrap_cnt); end
    total++; if ({wrap_ovf, err, evt_valid, evt_drop} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {wrap_ovf, err, evt_valid, evt_drop}); end
    total++; if (err_cnt !== 8'd0 || evt_data !== 8'd0) begin bad++; $display("FAIL reset_cnt_data got=%h/%h want=00/00", err_cnt, evt_data); end
    #3 rst = 1'b0;
  endtask

  task automatic test_up_wrap;
    cyc(1'b1, 4'd0, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 11; k++) begin
      cyc(1'b1, 4'(k), 1'b1, 1'b0, 4'd0);
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL up_step%0d_valid got=%b want=0", k, evt_valid); end
    end
    cyc(1'b1, 4'd0, 1'b1, 1'b0, 4'd0);
    total++; if (wrap_cnt !== 8'd1) begin bad++; $display("FAIL up_wrap_cnt got=%h want=01", wrap_cnt); end
    total++; if (evt_valid !== 1'b1 || evt_data !== 8'h50) begin bad++; $display("FAIL up_wrap_evt got=%b/%h want=1/50", evt_valid, evt_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL up_wrap_err got=%b want=0", err); end
  endtask

  task automatic test_down_wrap;
    evt_ready = 1'b1;
    cyc(1'b1, 4'd1, 1'b0, 1'b0, 4'd0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL dn_pop_valid got=%b want=0", evt_valid); end
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 4'd11, 1'b0, 1'b0, 4'd0);
    total++; if (wrap_cnt !== 8'd0) begin bad++; $display("FAIL dn_wrap_cnt got=%h want=00", wrap_cnt); end
    total++; if (evt_valid !== 1'b1 || evt_data !== 8'h6B) begin bad++; $display("FAIL dn_wrap_evt got=%b/%h want=1/6b", evt_valid, evt_data); end
    cyc(1'b1, 4'd10, 1'b0, 1'b0, 4'd0);
    total++; if (evt_valid !== 1'b0 || wrap_cnt !== 8'd0) begin bad++; $display("FAIL dn_step got=%b/%h want=0/00", evt_valid, wrap_cnt); end
  endtask

  task automatic test_load;
    resync(4'd3, 1'b1, 1'b1, 4'd7);
    cyc(1'b1, 4'd7, 1'b1, 1'b0, 4'd0);
    total++; if (evt_valid !== 1'b1 || evt_data !== 8'h37) begin bad++; $display("FAIL load_evt got=%b/%h want=1/37", evt_valid, evt_data); end
    total++; if (wrap_cnt !== 8'd0) begin bad++; $display("FAIL load_wrap_cnt got=%h want=00", wrap_cnt); end
    resync(4'd3, 1'b1, 1'b1, 4'd13);
    cyc(1'b1, 4'd4, 1'b1, 1'b0, 4'd0);
    total++; if (evt_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL load_ignored got=%b/%b want=0/0", evt_valid, err); end
  endtask

  task automatic test_errors;
    resync(4'd3, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 4'd5, 1'b1, 1'b0, 4'd0);
    total++; if (err !== 1'b1 || err_cnt !== 8'd1) begin bad++; $display("FAIL err_first got=%b/%0d want=1/1", err, err_cnt); end
    total++; if (evt_valid !== 1'b1 || evt_data !== 8'hF5) begin bad++; $display("FAIL err_evt got=%b/%h want=1/f5", evt_valid, evt_data); end
    cyc(1'b1, 4'd14, 1'b1, 1'b0, 4'd0);
    total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL range_cnt got=%0d want=2", err_cnt); end
    total++; if (evt_valid !== 1'b1 || evt_data !== 8'hDE) begin bad++; $display("FAIL range_evt got=%b/%h want=1/de", evt_valid, evt_data); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_seq [3];
    exp_seq = '{8'h50, 8'h6B, 8'hF5};
    evt_ready = 1'b1;
    resync(4'd11, 1'b1, 1'b0, 4'd0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", evt_valid); end
    evt_ready = 1'b0;
    // Alternating wraps: 50, 6B, 50, 6B, then 50 and 6B dropped
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cyc(1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
      else            cyc(1'b1, 4'd11, 1'b1, 1'b0, 4'd0);
      total++; if (evt_valid !== 1'b1 || evt_data !== 8'h50) begin bad++; $display("FAIL bp_head%0d got=%b/%h want=1/50", i, evt_valid, evt_data); end
      total++; if (evt_drop !== (i >= 4)) begin bad++; $display("FAIL bp_drop%0d got=%b want=%b", i, evt_drop, (i >= 4)); end
    end
    total++; if (wrap_cnt !== 8'd0) begin bad++; $display("FAIL bp_wrap_cnt got=%h want=00", wrap_cnt); end
    // Push while full with a simultaneous pop: the error event must be kept
    evt_ready = 1'b1;
    cyc(1'b1, 4'd5, 1'b1, 1'b0, 4'd0);
    total++; if (evt_valid !== 1'b1 || evt_data !== 8'h6B) begin bad++; $display("FAIL bp_fullpop_head got=%b/%h want=1/6b", evt_valid, evt_data); end
    total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL bp_err_cnt got=%0d want=3", err_cnt); end
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
      total++; if (evt_valid !== 1'b1 || evt_data !== exp_seq[j]) begin bad++; $display("FAIL bp_drain%0d got=%b/%h want=1/%h", j, evt_valid, evt_data, exp_seq[j]); end
    end
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", evt_valid); end
  endtask

  task automatic test_overflow_reset;
    evt_ready = 1'b1;
    resync(4'd11, 1'b1, 1'b0, 4'd0);
    // Each pair: wrap 11->0 with a load of 11 applied, then the load back to 11
    for (int i = 0; i < 255; i++) begin
      cyc(1'b1, 4'd0, 1'b1, 1'b1, 4'd11);
      cyc(1'b1, 4'd11, 1'b1, 1'b0, 4'd0);
    end
    total++; if (wrap_cnt !== 8'd255 || wrap_ovf !== 1'b0) begin bad++; $display("FAIL ovf_255 got=%h/%b want=ff/0", wrap_cnt, wrap_ovf); end
    cyc(1'b1, 4'd0, 1'b1, 1'b1, 4'd11);
    total++; if (wrap_cnt !== 8'd0 || wrap_ovf !== 1'b1) begin bad++; $display("FAIL ovf_256 got=%h/%b want=00/1", wrap_cnt, wrap_ovf); end
    cyc(1'b1, 4'd11, 1'b1, 1'b0, 4'd0);
    evt_ready = 1'b0;
    cyc(1'b1, 4'd0, 1'b1, 1'b0, 4'd0);
    total++; if (wrap_cnt !== 8'd1 || evt_valid !== 1'b1) begin bad++; $display("FAIL pre_rst got=%h/%b want=01/1", wrap_cnt, evt_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (wrap_cnt !== 8'd0 || err_cnt !== 8'd0 || evt_data !== 8'd0) begin bad++; $display("FAIL mid_rst_vals got=%h/%h/%h want=00/00/00", wrap_cnt, err_cnt, evt_data); end
    total++; if ({wrap_ovf, err, evt_valid, evt_drop} !== 4'b0000) begin bad++; $display("FAIL mid_rst_flags got=%b want=0000", {wrap_ovf, err, evt_valid, evt_drop}); end
    #1 rst = 1'b0;
    cyc(1'b1, 4'd7, 1'b1, 1'b0, 4'd0);
    total++; if (evt_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL post_rst_first got=%b/%b want=0/0", evt_valid, err); end
    cyc(1'b1, 4'd8, 1'b1, 1'b0, 4'd0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL post_rst_step got=%b want=0", evt_valid); end
    cyc(1'b1, 4'd10, 1'b1, 1'b0, 4'd0);
    total++; if (evt_valid !== 1'b1 || evt_data !== 8'hFA || err_cnt !== 8'd1) begin bad++; $display("FAIL post_rst_err got=%b/%h/%0d want=1/fa/1", evt_valid, evt_data, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_errors();
    test_back_to_back();
    test_overflow_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
